// File: rtl/nes_mem_pkg.sv
// rtl/nes_mem_pkg.sv - shared constants and types for the NES memory blocks
//
// Purpose: read/write mode selectors and the clear-engine state type used by
// nes_sp_ram and nes_ram_clear_seq.
// Ports: none (package).

package nes_mem_pkg;

  // READ_MODE values
  localparam int RD_BYPASS  = 0;  // dout = stage 1, one-cycle read
  localparam int RD_PIPE    = 1;  // dout = stage 2, gated by oce

  // WRITE_MODE values
  localparam int WR_NORMAL  = 0;  // dout holds across writes
  localparam int WR_THROUGH = 1;  // dout shows the merged new word
  localparam int WR_RBW     = 2;  // dout shows the word before the write

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

endpackage

// File: rtl/nes_ram_clear_seq.sv
// rtl/nes_ram_clear_seq.sv - clear engine that fills the RAM with a constant
//
// Purpose: sweeps every word address once, raising busy_o for exactly DEPTH
// cycles, either right after reset release or on a clr_i pulse.
// Ports:
//   clk_i       system clock
//   reset_n_i   asynchronous active-low reset
//   clr_i       single-cycle clear request (ignored while clearing)
//   busy_o      clear in progress; doubles as the clear write enable
//   clr_addr_o  word address written by the clear engine this cycle

module nes_ram_clear_seq
  import nes_mem_pkg::*;
#(
  parameter int ADDR_W         = 11,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              clr_i,
  output logic              busy_o,
  output logic [ADDR_W-1:0] clr_addr_o
);

  clr_state_e        state_q;
  logic [ADDR_W-1:0] addr_q;
  logic              busy_q;
  // Set by reset so the first edge after release can launch the clear.
  logic              start_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      busy_q  <= 1'b0;
      start_q <= (CLEAR_ON_RESET != 0);
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_q || clr_i) begin
            state_q <= ST_CLEAR;
            busy_q  <= 1'b1;
            addr_q  <= '0;
            start_q <= 1'b0;
          end
        end
        ST_CLEAR: begin
          // The word at addr_q is written on this edge; the last one ends the sweep.
          addr_q <= addr_q + ADDR_W'(1);
          if (addr_q == {ADDR_W{1'b1}}) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o     = busy_q;
  assign clr_addr_o = addr_q;

endmodule

// File: rtl/nes_sp_ram.sv
// rtl/nes_sp_ram.sv - parametrised single-port synchronous RAM with clear engine
//
// Purpose: byte-lane writable RAM for NES work RAM, VRAM, palette and cart RAM,
// with selectable read latency, write-port output behaviour and a fill engine.
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset (output stages and clear FSM only)
//   ce       access enable
//   wre      write enable, qualified by ce
//   be       byte-lane write enables, qualified by ce & wre
//   ad       word address
//   din      write data
//   oce      output register enable (pipelined read mode only)
//   clr      single-cycle clear request
//   dout     read data
//   busy     clear engine running; user accesses are ignored

module nes_sp_ram
  import nes_mem_pkg::*;
#(
  parameter int                DATA_W         = 8,
  parameter int                ADDR_W         = 11,
  parameter int                READ_MODE      = RD_BYPASS,
  parameter int                WRITE_MODE     = WR_NORMAL,
  parameter int                CLEAR_ON_RESET = 1,
  parameter logic [DATA_W-1:0] FILL_VALUE     = '0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ce,
  input  logic                  wre,
  input  logic [DATA_W/8-1:0]   be,
  input  logic [ADDR_W-1:0]     ad,
  input  logic [DATA_W-1:0]     din,
  input  logic                  oce,
  input  logic                  clr,
  output logic [DATA_W-1:0]     dout,
  output logic                  busy
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int NB    = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] clr_addr;
  logic [DATA_W-1:0] old_word;
  logic [DATA_W-1:0] merged_word;
  logic [DATA_W-1:0] s1_q;
  logic [DATA_W-1:0] s2_q;
  logic              user_acc;

  nes_ram_clear_seq #(
    .ADDR_W         (ADDR_W),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear (
    .clk_i      (clk),
    .reset_n_i  (reset_n),
    .clr_i      (clr),
    .busy_o     (busy),
    .clr_addr_o (clr_addr)
  );

  assign user_acc = ce && !busy;
  assign old_word = mem[ad];

  always_comb begin
    merged_word = old_word;
    for (int i = 0; i < NB; i++) begin
      if (be[i]) merged_word[8*i +: 8] = din[8*i +: 8];
    end
  end

  // Array has no reset; the clear engine owns the write port while busy.
  always_ff @(posedge clk) begin
    if (busy) begin
      mem[clr_addr] <= FILL_VALUE;
    end else if (user_acc && wre) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) mem[ad][8*i +: 8] <= din[8*i +: 8];
      end
    end
  end

  // Stage 1 only moves on user accesses; clear writes never disturb it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q <= '0;
    end else if (user_acc) begin
      if (!wre) begin
        s1_q <= old_word;
      end else begin
        case (WRITE_MODE)
          WR_THROUGH: s1_q <= merged_word;
          WR_RBW:     s1_q <= old_word;
          default:    s1_q <= s1_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_q <= '0;
    end else if (READ_MODE == RD_PIPE && oce) begin
      s2_q <= s1_q;
    end
  end

  assign dout = (READ_MODE == RD_PIPE) ? s2_q : s1_q;

endmodule

// File: tb/tb_nes_sp_ram.sv
// tb/tb_nes_sp_ram.sv - scoreboard bench for nes_sp_ram across its modes

module tb_nes_sp_ram;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n, ce, wre, oce, clr;
  logic [3:0] ad;
  logic [7:0] din8;
  logic [0:0] be8;
  logic [15:0] din16;
  logic [1:0] be16;

  logic [7:0]  dout_m0, dout_m1, dout_m2, dout_p;
  logic [15:0] dout_w;
  logic        busy_m0, busy_m1, busy_m2, busy_p, busy_w;

  // m0/m1/m2: bypass read with write modes 0/1/2; p: pipelined; w: 16-bit
  nes_sp_ram #(.DATA_W(8), .ADDR_W(4), .READ_MODE(0), .WRITE_MODE(0),
               .CLEAR_ON_RESET(1), .FILL_VALUE(8'hA5)) u_m0 (
    .clk(clk), .reset_n(reset_n), .ce(ce), .wre(wre), .be(be8), .ad(ad),
    .din(din8), .oce(oce), .clr(clr), .dout(dout_m0), .busy(busy_m0));
  nes_sp_ram #(.DATA_W(8), .ADDR_W(4), .READ_MODE(0), .WRITE_MODE(1),
               .CLEAR_ON_RESET(1), .FILL_VALUE(8'hA5)) u_m1 (
    .clk(clk), .reset_n(reset_n), .ce(ce), .wre(wre), .be(be8), .ad(ad),
    .din(din8), .oce(oce), .clr(clr), .dout(dout_m1), .busy(busy_m1));
  nes_sp_ram #(.DATA_W(8), .ADDR_W(4), .READ_MODE(0), .WRITE_MODE(2),
               .CLEAR_ON_RESET(1), .FILL_VALUE(8'hA5)) u_m2 (
    .clk(clk), .reset_n(reset_n), .ce(ce), .wre(wre), .be(be8), .ad(ad),
    .din(din8), .oce(oce), .clr(clr), .dout(dout_m2), .busy(busy_m2));
  nes_sp_ram #(.DATA_W(8), .ADDR_W(4), .READ_MODE(1), .WRITE_MODE(0),
               .CLEAR_ON_RESET(1), .FILL_VALUE(8'hA5)) u_p (
    .clk(clk), .reset_n(reset_n), .ce(ce), .wre(wre), .be(be8), .ad(ad),
    .din(din8), .oce(oce), .clr(clr), .dout(dout_p), .busy(busy_p));
  nes_sp_ram #(.DATA_W(16), .ADDR_W(4), .READ_MODE(0), .WRITE_MODE(0),
               .CLEAR_ON_RESET(1), .FILL_VALUE(16'hBEEF)) u_w (
    .clk(clk), .reset_n(reset_n), .ce(ce), .wre(wre), .be(be16), .ad(ad),
    .din(din16), .oce(oce), .clr(clr), .dout(dout_w), .busy(busy_w));

  typedef struct {
    int          due;
    int          inst;
    logic [15:0] exp;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   passed = 0;
  int   total  = 0;
  int   fails  = 0;
  int   n;

  function automatic logic [15:0] dout_of(int inst);
    case (inst)
      0:       return {8'h00, dout_m0};
      1:       return {8'h00, dout_m1};
      2:       return {8'h00, dout_m2};
      3:       return {8'h00, dout_p};
      default: return dout_w;
    endcase
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input int inst, input int lat, input logic [15:0] e, input string tag);
    sb.push_back('{cyc + lat, inst, e, tag});
  endtask

  // One clock: advance at posedge, compare due entries at the following negedge.
  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        check(sb[i].tag, dout_of(sb[i].inst), sb[i].exp);
        sb.delete(i);
      end
    end
  endtask

  task automatic read_all(input logic [3:0] a, input logic [7:0] e8, input logic [15:0] e16);
    ce = 1'b1; wre = 1'b0; ad = a;
    push(0, 1, {8'h00, e8}, $sformatf("rd_m0_a%0d", a));
    push(1, 1, {8'h00, e8}, $sformatf("rd_m1_a%0d", a));
    push(2, 1, {8'h00, e8}, $sformatf("rd_m2_a%0d", a));
    push(3, 2, {8'h00, e8}, $sformatf("rd_p_a%0d", a));
    push(4, 1, e16,         $sformatf("rd_w_a%0d", a));
    tick();
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d8, input logic b8,
                    input logic [15:0] d16, input logic [1:0] b16);
    ce = 1'b1; wre = 1'b1; ad = a;
    din8 = d8; be8 = b8; din16 = d16; be16 = b16;
    tick();
  endtask

  task automatic count_busy(output int cnt);
    cnt = 0;
    for (int k = 0; k < 64; k++) begin
      if (!busy_m0) break;
      cnt++;
      tick();
    end
  endtask

  initial begin
    reset_n = 1'b0; ce = 1'b0; wre = 1'b0; oce = 1'b1; clr = 1'b0;
    ad = '0; din8 = '0; be8 = '0; din16 = '0; be16 = '0;
    tick(); tick();

    // Held reset: outputs cleared, engine idle
    check("rst_busy", {15'd0, busy_m0}, 16'd0);
    check("rst_dout_m0", dout_of(0), 16'h0000);
    check("rst_dout_p", dout_of(3), 16'h0000);
    check("rst_dout_w", dout_of(4), 16'h0000);

    // Power-on clear runs exactly DEPTH cycles
    reset_n = 1'b1;
    tick();
    count_busy(n);
    check("por_busy_len", 16'(n), 16'd16);
    for (int i = 0; i < 16; i++) read_all(4'(i), 8'hA5, 16'hBEEF);
    ce = 1'b0; tick(); tick();

    // Byte-lane merge on the 16-bit instance; be=0 on the 8-bit ones
    wr(4'd3, 8'h00, 1'b0, 16'h1234, 2'b11);
    wr(4'd3, 8'h00, 1'b0, 16'hFF00, 2'b10);
    read_all(4'd3, 8'hA5, 16'hFF34);

    // Write-mode sweep at address 5
    wr(4'd5, 8'h11, 1'b1, 16'h0000, 2'b00);
    read_all(4'd0, 8'hA5, 16'hBEEF);
    ce = 1'b1; wre = 1'b1; ad = 4'd5; din8 = 8'h22; be8 = 1'b1; be16 = 2'b00;
    push(0, 1, 16'h00A5, "wm0_hold");
    push(1, 1, 16'h0022, "wm1_through");
    push(2, 1, 16'h0011, "wm2_rbw");
    tick();
    read_all(4'd5, 8'h22, 16'hBEEF);
    ce = 1'b1; wre = 1'b1; ad = 4'd5; din8 = 8'h99; be8 = 1'b0;
    push(0, 1, 16'h0022, "be0_wm0");
    push(1, 1, 16'h0022, "be0_wm1");
    push(2, 1, 16'h0022, "be0_wm2");
    tick();
    read_all(4'd5, 8'h22, 16'hBEEF);
    ce = 1'b0; tick(); tick();

    // Pipelined read held off by oce
    wr(4'd7, 8'h3C, 1'b1, 16'h0000, 2'b00);
    read_all(4'd0, 8'hA5, 16'hBEEF);
    ce = 1'b0; tick();
    ce = 1'b1; wre = 1'b0; ad = 4'd7; oce = 1'b0;
    push(3, 1, 16'h00A5, "pipe_oce0_c1");
    push(0, 1, 16'h003C, "pipe_ref_m0");
    tick();
    ce = 1'b0;
    push(3, 1, 16'h00A5, "pipe_oce0_c2");
    tick();
    push(3, 1, 16'h00A5, "pipe_oce0_c3");
    tick();
    oce = 1'b1;
    push(3, 1, 16'h003C, "pipe_oce1");
    tick();

    // Requested clear: writes during busy dropped, second clr ignored
    clr = 1'b1; tick(); clr = 1'b0;
    n = 0;
    for (int k = 0; k < 64; k++) begin
      if (!busy_m0) break;
      n++;
      ce = 1'b1; wre = 1'b1; ad = 4'(k); din8 = 8'h77; be8 = 1'b1;
      din16 = 16'h7777; be16 = 2'b11;
      clr = (k == 5);
      tick();
    end
    ce = 1'b0; wre = 1'b0; clr = 1'b0;
    check("clr_busy_len", 16'(n), 16'd16);
    for (int i = 0; i < 16; i++) read_all(4'(i), 8'hA5, 16'hBEEF);
    ce = 1'b0; tick(); tick();

    // Reset at clear address 8 aborts, then the clear restarts in full
    clr = 1'b1; tick(); clr = 1'b0;
    repeat (8) tick();
    check("mid_busy_pre", {15'd0, busy_m0}, 16'd1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy", {15'd0, busy_m0}, 16'd0);
    check("mid_rst_dout_m0", dout_of(0), 16'h0000);
    check("mid_rst_dout_p", dout_of(3), 16'h0000);
    check("mid_rst_dout_w", dout_of(4), 16'h0000);
    tick();
    reset_n = 1'b1;
    tick();
    count_busy(n);
    check("restart_busy_len", 16'(n), 16'd16);
    read_all(4'd0, 8'hA5, 16'hBEEF);
    read_all(4'd8, 8'hA5, 16'hBEEF);
    read_all(4'd15, 8'hA5, 16'hBEEF);
    ce = 1'b0; tick(); tick();

    check("sb_drained", 16'(sb.size()), 16'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
